// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg -- shared types and constants for the ctrl_seq instruction sequencer.
//
// Contents:
//   ctrl_state_t  sequencer FSM state (IDLE, RUN, MEM, HALT)
//   ctrl_op_t     decoded instruction class
//   ctrl_ctl_t    bundle of per-cycle control outputs
//   HALT_CODE, ADDR_REG, MOVE_ALUOP and the fixed destination registers
//   ctl_idle()    control bundle for a cycle with no instruction effect
//   is_mem_op()   true for instruction classes that occupy the data memory
// ---------------------------------------------------------------------------
package ctrl_pkg;

   localparam logic [8:0] HALT_CODE  = 9'h0FF;
   localparam logic [2:0] ADDR_REG   = 3'd6;
   localparam logic [2:0] MOVE_ALUOP = 3'b111;
   localparam logic [2:0] CMP_WD     = 3'd5;
   localparam logic [2:0] LDC_WD     = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_MEM  = 2'd2,
      ST_HALT = 2'd3
   } ctrl_state_t;

   typedef enum logic [2:0] {
      OP_RTYPE  = 3'd0,
      OP_CMP    = 3'd1,
      OP_BRANCH = 3'd2,
      OP_LOAD   = 3'd3,
      OP_LDC    = 3'd4,
      OP_STORE  = 3'd5,
      OP_MOVE   = 3'd6,
      OP_HALT   = 3'd7
   } ctrl_op_t;

   typedef struct packed {
      logic [2:0] aluop;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [2:0] wd;
      logic [4:0] ldc_val;
      logic [5:0] jaddr;
      logic       wen_r;
      logic       wen_d;
      logic       ren_d;
      logic       mem_to_reg;
      logic       jen;
      logic       ldcen;
      logic       busy;
   } ctrl_ctl_t;

   // A cycle with no instruction effect still selects memory-to-register
   // on the write-back mux; everything else is quiet.
   function automatic ctrl_ctl_t ctl_idle();
      ctrl_ctl_t c;
      c            = '0;
      c.mem_to_reg = 1'b1;
      return c;
   endfunction

   function automatic logic is_mem_op(input ctrl_op_t op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// ctrl_seq_if -- instruction handshake between an instruction source (master)
// and the ctrl_seq sequencer (slave).
//
// Signals:
//   InstValid  master->slave  mach_code is valid
//   mach_code  master->slave  9-bit instruction word
//   InstReady  slave->master  sequencer can accept an instruction this cycle
//   Flag       master->slave  branch condition, only with CTRL_SEQ_COND_BRANCH_EN
//
// Handshake: an instruction transfers on a rising clock edge where
// InstValid && InstReady. InstValid while InstReady is low is ignored
// and has no effect; the master may change mach_code freely in that case.
// ---------------------------------------------------------------------------
interface ctrl_seq_if;

   logic       InstValid;
   logic [8:0] mach_code;
   logic       InstReady;
`ifdef CTRL_SEQ_COND_BRANCH_EN
   logic       Flag;
`endif

   modport master (
      output InstValid,
      output mach_code,
`ifdef CTRL_SEQ_COND_BRANCH_EN
      output Flag,
`endif
      input  InstReady
   );

   modport slave (
      input  InstValid,
      input  mach_code,
`ifdef CTRL_SEQ_COND_BRANCH_EN
      input  Flag,
`endif
      output InstReady
   );

endinterface

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode -- purely combinational instruction decoder for ctrl_seq.
//
// Ports:
//   code_i   in   9-bit instruction word
//   flag_i   in   branch condition (only with CTRL_SEQ_COND_BRANCH_EN)
//   op_o     out  instruction class
//   ctl_o    out  control bundle for the first cycle after acceptance
//
// Loads report wen_r=0: the register write of a load belongs to the last
// memory cycle, which only the sequencer knows about.
// Config macro: CTRL_SEQ_COND_BRANCH_EN (branch enable follows flag_i).
// ---------------------------------------------------------------------------
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [8:0] code_i,
`ifdef CTRL_SEQ_COND_BRANCH_EN
   input  logic       flag_i,
`endif
   output ctrl_op_t   op_o,
   output ctrl_ctl_t  ctl_o
);

   ctrl_op_t  op;
   ctrl_ctl_t ctl;

   always_comb begin
      op  = OP_RTYPE;
      ctl = ctl_idle();

      // Halt shares bit8=0 with the register formats, so it is checked first.
      if (code_i == HALT_CODE) begin
         op = OP_HALT;
      end else if (!code_i[8]) begin
         op = (code_i[8:5] == 4'b0110) ? OP_CMP : OP_RTYPE;
      end else begin
         unique case (code_i[7:6])
            2'b00:   op = OP_BRANCH;
            2'b01:   op = OP_STORE;
            2'b10:   op = code_i[0] ? OP_LDC : OP_LOAD;
            default: op = OP_MOVE;
         endcase
      end

      unique case (op)
         OP_RTYPE, OP_CMP: begin
            ctl.aluop = code_i[7:5];
            ctl.ra    = {1'b0, code_i[4:3]};
            ctl.rb    = code_i[2:0];
            ctl.wd    = (op == OP_CMP) ? CMP_WD : code_i[2:0];
            ctl.wen_r = 1'b1;
         end
         OP_BRANCH: begin
            ctl.jaddr = code_i[5:0];
`ifdef CTRL_SEQ_COND_BRANCH_EN
            ctl.jen   = flag_i;
`else
            ctl.jen   = 1'b1;
`endif
         end
         OP_LOAD: begin
            ctl.ra         = ADDR_REG;
            ctl.wd         = code_i[5:3];
            ctl.mem_to_reg = 1'b0;
            ctl.ren_d      = 1'b1;
            ctl.busy       = 1'b1;
         end
         OP_LDC: begin
            ctl.ldcen   = 1'b1;
            ctl.ldc_val = code_i[5:1];
            ctl.wd      = LDC_WD;
            ctl.wen_r   = 1'b1;
         end
         OP_STORE: begin
            ctl.ra    = ADDR_REG;
            ctl.rb    = code_i[5:3];
            ctl.wen_d = 1'b1;
            ctl.busy  = 1'b1;
         end
         OP_MOVE: begin
            ctl.aluop = MOVE_ALUOP;
            ctl.ra    = code_i[5:3];
            ctl.wd    = code_i[2:0];
            ctl.wen_r = 1'b1;
         end
         default: ;  // OP_HALT: no register or memory effect
      endcase
   end

   assign op_o  = op;
   assign ctl_o = ctl;

endmodule

// File: rtl/ctrl_seq.sv
// ---------------------------------------------------------------------------
// ctrl_seq -- 9-bit instruction sequencer: accepts instructions over a
// valid/ready handshake, decodes them and drives registered datapath controls
// one cycle after acceptance. Loads and stores hold the sequencer in MEM for
// MEM_LAT cycles; 9'h0FF halts until Start.
//
// Parameters: MEM_LAT (1..15) cycles per data-memory access, JW (>=6) Jptr width.
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   Start                   begin / restart (aborts any in-flight op)
//   inst                    ctrl_seq_if.slave instruction handshake
//   Aluop, Ra, Rb, Wd       ALU op and register selects
//   LdcVal, Jptr            load-constant value, jump target
//   WenR, WenD, RenD        register write, data write, data read
//   MemToReg, Jen, Ldcen    write-back select, jump enable, load-constant enable
//   Done, Busy              halted, memory op in flight
//   DbgState                current FSM state
// Config macro: CTRL_SEQ_COND_BRANCH_EN (Jen = inst.Flag sampled at acceptance).
// ---------------------------------------------------------------------------
module ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int JW      = 8
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Start,
   ctrl_seq_if.slave     inst,
   output logic [2:0]    Aluop,
   output logic [2:0]    Ra,
   output logic [2:0]    Rb,
   output logic [2:0]    Wd,
   output logic [4:0]    LdcVal,
   output logic [JW-1:0] Jptr,
   output logic          WenR,
   output logic          WenD,
   output logic          RenD,
   output logic          MemToReg,
   output logic          Jen,
   output logic          Ldcen,
   output logic          Done,
   output logic          Busy,
   output ctrl_state_t   DbgState
);

   // First MEM cycle is the one right after acceptance, so the wait counter
   // starts one below the latency and the op ends when it has reached 0.
   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   ctrl_state_t state_q;
   logic [3:0]  cnt_q;
   ctrl_ctl_t   ctl_q;
   logic        done_q;

   ctrl_op_t    dec_op;
   ctrl_ctl_t   dec_ctl;
   ctrl_ctl_t   acc_ctl;
   logic        accept;

   ctrl_decode u_decode (
      .code_i (inst.mach_code),
`ifdef CTRL_SEQ_COND_BRANCH_EN
      .flag_i (inst.Flag),
`endif
      .op_o   (dec_op),
      .ctl_o  (dec_ctl)
   );

   assign accept = (state_q == ST_RUN) && inst.InstValid;

   // A single-cycle load is its own last cycle, so it writes immediately.
   always_comb begin
      acc_ctl = dec_ctl;
      if ((dec_op == OP_LOAD) && (MEM_LAT == 1)) begin
         acc_ctl.wen_r = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ctl_q   <= '0;
         done_q  <= 1'b0;
      end else if (Start) begin
         // Start wins over everything, dropping any pending load write.
         state_q <= ST_RUN;
         cnt_q   <= '0;
         ctl_q   <= ctl_idle();
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
               ctl_q <= ctl_idle();
               if (accept) begin
                  ctl_q <= acc_ctl;
                  if (dec_op == OP_HALT) begin
                     state_q <= ST_HALT;
                     done_q  <= 1'b1;
                  end else if (is_mem_op(dec_op) && (MEM_LAT > 1)) begin
                     state_q <= ST_MEM;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            ST_MEM: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_RUN;
                  ctl_q   <= ctl_idle();
               end else begin
                  // Selects stay stable for the whole access; the data write
                  // is a first-cycle pulse and a load writes back on its last.
                  cnt_q       <= cnt_q - 4'd1;
                  ctl_q.wen_d <= 1'b0;
                  ctl_q.wen_r <= ctl_q.ren_d && (cnt_q == 4'd1);
               end
            end
            ST_HALT: ctl_q <= ctl_idle();
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign inst.InstReady = (state_q == ST_RUN);

   assign Aluop    = ctl_q.aluop;
   assign Ra       = ctl_q.ra;
   assign Rb       = ctl_q.rb;
   assign Wd       = ctl_q.wd;
   assign LdcVal   = ctl_q.ldc_val;
   assign Jptr     = JW'(ctl_q.jaddr);
   assign WenR     = ctl_q.wen_r;
   assign WenD     = ctl_q.wen_d;
   assign RenD     = ctl_q.ren_d;
   assign MemToReg = ctl_q.mem_to_reg;
   assign Jen      = ctl_q.jen;
   assign Ldcen    = ctl_q.ldcen;
   assign Busy     = ctl_q.busy;
   assign Done     = done_q;
   assign DbgState = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_ctrl_seq -- directed self-checking bench for ctrl_seq (MEM_LAT=3, JW=8).
// Expected output vectors are written out by hand per step; each check
// compares the full output word plus, where relevant, the FSM state.
// ---------------------------------------------------------------------------
module tb_ctrl_seq;
   import ctrl_pkg::*;

   localparam int MEM_LAT = 3;
   localparam int JW      = 8;

   logic          Clk;
   logic          Reset_n;
   logic          Start;
   logic [2:0]    Aluop, Ra, Rb, Wd;
   logic [4:0]    LdcVal;
   logic [JW-1:0] Jptr;
   logic          WenR, WenD, RenD, MemToReg, Jen, Ldcen, Done, Busy;
   ctrl_state_t   DbgState;

   int total;
   int bad;

   // expected output fields
   logic [2:0]    e_aluop, e_ra, e_rb, e_wd;
   logic [4:0]    e_ldc;
   logic [JW-1:0] e_jptr;
   logic          e_wenr, e_wend, e_rend, e_m2r, e_jen, e_ldcen, e_done, e_busy, e_ready;

   ctrl_seq_if ifc ();

   ctrl_seq #(.MEM_LAT(MEM_LAT), .JW(JW)) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Start    (Start),
      .inst     (ifc),
      .Aluop    (Aluop),
      .Ra       (Ra),
      .Rb       (Rb),
      .Wd       (Wd),
      .LdcVal   (LdcVal),
      .Jptr     (Jptr),
      .WenR     (WenR),
      .WenD     (WenD),
      .RenD     (RenD),
      .MemToReg (MemToReg),
      .Jen      (Jen),
      .Ldcen    (Ldcen),
      .Done     (Done),
      .Busy     (Busy),
      .DbgState (DbgState)
   );

   // ---------------- clock ----------------
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic exp_zero();
      e_aluop = '0; e_ra = '0; e_rb = '0; e_wd = '0; e_ldc = '0; e_jptr = '0;
      e_wenr = 0; e_wend = 0; e_rend = 0; e_m2r = 0; e_jen = 0; e_ldcen = 0;
      e_done = 0; e_busy = 0; e_ready = 0;
   endtask

   // running, nothing issued: only MemToReg and InstReady high
   task automatic exp_idle();
      exp_zero();
      e_m2r   = 1;
      e_ready = 1;
   endtask

   task automatic check(input string tag);
      logic [33:0] act;
      logic [33:0] exp;
      act = {Aluop, Ra, Rb, Wd, LdcVal, Jptr, WenR, WenD, RenD, MemToReg,
             Jen, Ldcen, Done, Busy, ifc.InstReady};
      exp = {e_aluop, e_ra, e_rb, e_wd, e_ldc, e_jptr, e_wenr, e_wend, e_rend, e_m2r,
             e_jen, e_ldcen, e_done, e_busy, e_ready};
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input ctrl_state_t exp);
      total++;
      assert (DbgState === exp) else begin
         bad++;
         $error("FAIL %s: observed state=%0d expected state=%0d", tag, DbgState, exp);
      end
   endtask

   // present one instruction for one edge; returns #1 after that edge
   task automatic issue(input logic [8:0] code);
      ifc.InstValid = 1'b1;
      ifc.mach_code = code;
      tick();
      ifc.InstValid = 1'b0;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      total         = 0;
      bad           = 0;
      Reset_n       = 1'b0;
      Start         = 1'b0;
      ifc.InstValid = 1'b0;
      ifc.mach_code = '0;
`ifdef CTRL_SEQ_COND_BRANCH_EN
      ifc.Flag      = 1'b1;
`endif
      tick();
      tick();

      // reset state: every output 0, IDLE
      exp_zero();
      check("reset_outputs");
      check_state("reset_state", ST_IDLE);
      Reset_n = 1'b1;

      // valid in IDLE is ignored
      ifc.InstValid = 1'b1;
      ifc.mach_code = 9'b0_010_01_011;
      tick();
      ifc.InstValid = 1'b0;
      exp_zero();
      check("idle_ignore");
      check_state("idle_ignore_state", ST_IDLE);

      // Start -> RUN
      pulse_start();
      exp_idle();
      check("start_run");
      check_state("start_state", ST_RUN);

      // R-type 0_010_01_011: Aluop=2 Ra=1 Rb=3 Wd=3 WenR
      issue(9'b0_010_01_011);
      exp_idle();
      e_aluop = 3'd2; e_ra = 3'd1; e_rb = 3'd3; e_wd = 3'd3; e_wenr = 1;
      check("rtype");
      tick();
      exp_idle();
      check("rtype_pulse_end");

      // compare 0_110_10_101 back-to-back with move 111_100_010
      issue(9'b0_110_10_101);
      exp_idle();
      e_aluop = 3'd6; e_ra = 3'd2; e_rb = 3'd5; e_wd = 3'd5; e_wenr = 1;
      check("compare");
      issue(9'b111_100_010);
      exp_idle();
      e_aluop = 3'b111; e_ra = 3'd4; e_wd = 3'd2; e_wenr = 1;
      check("move");

      // load constant 110_10110_1: LdcVal=22 Wd=6, single cycle
      issue(9'b110_10110_1);
      exp_idle();
      e_ldcen = 1; e_ldc = 5'd22; e_wd = 3'd6; e_wenr = 1;
      check("ldc");
      check_state("ldc_state", ST_RUN);
      tick();
      exp_idle();
      check("ldc_single");

      // branch 100_101010: Jptr=42
      issue(9'b100_101010);
      exp_idle();
      e_jptr = 8'd42; e_jen = 1;
      check("branch");
`ifdef CTRL_SEQ_COND_BRANCH_EN
      ifc.Flag = 1'b0;
      issue(9'b100_101010);
      ifc.Flag = 1'b1;
      exp_idle();
      e_jptr = 8'd42; e_jen = 0;
      check("branch_flag0");
`endif

      // load 110_010_00_0 with MEM_LAT=3; valid held during MEM is ignored
      issue(9'b110_010_00_0);
      exp_zero();
      e_ra = 3'd6; e_wd = 3'd2; e_rend = 1; e_busy = 1;
      check("load_c1");
      check_state("load_c1_state", ST_MEM);
      ifc.InstValid = 1'b1;
      ifc.mach_code = 9'b111_001_001;
      tick();
      check("load_c2");
      tick();
      e_wenr = 1;
      check("load_c3");
      ifc.InstValid = 1'b0;
      tick();
      exp_idle();
      check("load_done");
      check_state("load_done_state", ST_RUN);

      // store 101_100_000: WenD first cycle, Busy 3 cycles
      issue(9'b101_100_000);
      exp_zero();
      e_ra = 3'd6; e_rb = 3'd4; e_wend = 1; e_busy = 1; e_m2r = 1;
      check("store_c1");
      tick();
      e_wend = 0;
      check("store_c2");
      tick();
      check("store_c3");
      tick();
      exp_idle();
      check("store_done");

      // Start on load MEM cycle 2 aborts and drops the write-back
      issue(9'b110_011_00_0);
      tick();
      pulse_start();
      exp_idle();
      check("abort_load");
      check_state("abort_state", ST_RUN);
      tick();
      check("abort_no_wenr");

      // halt: Done held, not ready, valid ignored; Start resumes
      issue(9'h0FF);
      exp_idle();
      e_done = 1; e_ready = 0;
      check("halt");
      check_state("halt_state", ST_HALT);
      ifc.InstValid = 1'b1;
      ifc.mach_code = 9'b0_010_01_011;
      tick();
      ifc.InstValid = 1'b0;
      check("halt_held");
      pulse_start();
      exp_idle();
      check("halt_restart");
      check_state("halt_restart_state", ST_RUN);

      // reset during load MEM cycle 2: outputs drop at once, no write-back
      issue(9'b110_101_00_0);
      tick();
      exp_zero();
      e_ra = 3'd6; e_wd = 3'd5; e_rend = 1; e_busy = 1;
      check("rst_load_c2");
      #2;
      Reset_n = 1'b0;
      #1;
      exp_zero();
      check("async_reset");
      check_state("async_reset_state", ST_IDLE);
      tick();
      check("reset_no_wenr");
      Reset_n = 1'b1;

      // recovers normally after reset
      pulse_start();
      issue(9'b0_001_11_100);
      exp_idle();
      e_aluop = 3'd1; e_ra = 3'd3; e_rb = 3'd4; e_wd = 3'd4; e_wenr = 1;
      check("post_reset_rtype");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard stop in case the sequence ever stalls
   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
